// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period and high time of a divided clock, checks it against an expected period and flags errors, timeout and lock
module div_clk_monitor #(
  parameter int CNT_W = 16,
  parameter int EXP_PERIOD = 5,
  parameter int TOL = 0,
  parameter int TIMEOUT = 1023,
  parameter int LOCK_N = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             period_err,
  output logic             timeout,
  output logic             locked
);
  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [GW-1:0] LOCK_G = GW'(LOCK_N);
  localparam logic [CNT_W:0] EXP_X = (CNT_W + 1)'(EXP_PERIOD);
  localparam logic [CNT_W:0] TOL_X = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state, state_nx;
  logic s1, s2, s3, rise, fall, wdog, in_tol;
  logic [CNT_W-1:0] cnt, hi_tmp, hi_tmp_nx, period_nx, high_time_nx;
  logic [CNT_W:0] cnt_x, diff;
  logic [GW-1:0] good_cnt, good_cnt_nx;
  logic meas_valid_nx, period_err_nx, timeout_nx, locked_nx;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign wdog = (state != IDLE) && (cnt == TMO) && !rise;
  assign cnt_x = {1'b0, cnt};
  assign diff = (cnt_x >= EXP_X) ? cnt_x - EXP_X : EXP_X - cnt_x;
  assign in_tol = diff <= TOL_X;
  always_comb begin
    state_nx = state;
    hi_tmp_nx = hi_tmp;
    period_nx = period;
    high_time_nx = high_time;
    good_cnt_nx = good_cnt;
    meas_valid_nx = 1'b0;
    period_err_nx = period_err;
    timeout_nx = timeout;
    locked_nx = locked;
    if (clear) begin
      state_nx = IDLE;
      period_nx = '0;
      high_time_nx = '0;
      good_cnt_nx = '0;
      period_err_nx = 1'b0;
      timeout_nx = 1'b0;
      locked_nx = 1'b0;
    end else if (wdog) begin
      state_nx = IDLE;
      good_cnt_nx = '0;
      timeout_nx = 1'b1;
      locked_nx = 1'b0;
    end else begin
      case (state)
        IDLE: state_nx = rise ? HIGH : IDLE;
        HIGH: if (fall) begin
          hi_tmp_nx = cnt;
          state_nx = LOW;
        end
        LOW: if (rise) begin
          state_nx = HIGH;
          period_nx = cnt;
          high_time_nx = hi_tmp;
          meas_valid_nx = 1'b1;
          if (in_tol) begin
            good_cnt_nx = (good_cnt == LOCK_G) ? LOCK_G : good_cnt + GW'(1);
            locked_nx = good_cnt_nx == LOCK_G;
          end else begin
            good_cnt_nx = '0;
            period_err_nx = 1'b1;
            locked_nx = 1'b0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      {s1, s2, s3} <= '0;
      cnt <= '0;
      state <= IDLE;
      hi_tmp <= '0;
      period <= '0;
      high_time <= '0;
      good_cnt <= '0;
      meas_valid <= 1'b0;
      period_err <= 1'b0;
      timeout <= 1'b0;
      locked <= 1'b0;
    end else begin
      {s1, s2, s3} <= {sig_in, s1, s2};
      cnt <= rise ? CNT_W'(1) : (&cnt ? cnt : cnt + CNT_W'(1));
      state <= state_nx;
      hi_tmp <= hi_tmp_nx;
      period <= period_nx;
      high_time <= high_time_nx;
      good_cnt <= good_cnt_nx;
      meas_valid <= meas_valid_nx;
      period_err <= period_err_nx;
      timeout <= timeout_nx;
      locked <= locked_nx;
    end
  end
endmodule
